// File: rtl/serial_parity_frame_checker.sv
// rtl/serial_parity_frame_checker.sv - framed serial parity checker with running parity and saturating error counter
module serial_parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clock,      // single system clock
    input  logic             reset,      // synchronous, active-high
    input  logic             in_valid,   // qualifies in
    input  logic             in,         // serial data / parity bit
    input  logic             odd_mode,   // 0 = even, 1 = odd parity
    input  logic             clear_cnt,  // synchronous clear of err_count
    output logic             parity,     // running XOR of current frame data bits
    output logic             in_frame,   // frame in progress
    output logic             frame_done, // one-cycle pulse after parity bit
    output logic             parity_err, // one-cycle pulse on parity mismatch
    output logic [CNT_W-1:0] err_count   // saturating parity error count
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             parity_d, in_frame_d, done_d, err_d;
    logic [CNT_W-1:0] count_d;
    logic             mismatch;
    logic             err_inc;

    // State register: every output is registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_DATA;
            cnt        <= '0;
            parity     <= 1'b0;
            in_frame   <= 1'b0;
            frame_done <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            parity     <= parity_d;
            in_frame   <= in_frame_d;
            frame_done <= done_d;
            parity_err <= err_d;
            err_count  <= count_d;
        end
    end

    // Next-state logic: counter advances only on accepted data bits.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (in_valid) begin
            case (state)
                S_DATA: begin
                    if (cnt == LAST) begin
                        state_d = S_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                S_PARITY: state_d = S_DATA;
                default:  state_d = S_DATA;
            endcase
        end
    end

    // The received parity bit must equal data parity, inverted in odd mode.
    assign mismatch = in != (parity ^ odd_mode);
    assign err_inc  = in_valid && (state == S_PARITY) && mismatch;

    // Output logic: next values of the registered outputs.
    always_comb begin
        parity_d   = parity;
        in_frame_d = in_frame;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (in_valid) begin
            case (state)
                S_DATA: begin
                    parity_d   = parity ^ in;
                    in_frame_d = 1'b1;
                end
                S_PARITY: begin
                    parity_d   = 1'b0;
                    in_frame_d = 1'b0;
                    done_d     = 1'b1;
                    err_d      = mismatch;
                end
                default: begin
                    parity_d   = 1'b0;
                    in_frame_d = 1'b0;
                end
            endcase
        end

        // A clear coinciding with a new error keeps that error as a count of one.
        if (clear_cnt) begin
            count_d = err_inc ? CNT_W'(1) : '0;
        end else if (err_inc && (err_count != {CNT_W{1'b1}})) begin
            count_d = err_count + CNT_W'(1);
        end else begin
            count_d = err_count;
        end
    end

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// tb/tb_serial_parity_frame_checker.sv - directed self-checking bench for serial_parity_frame_checker
module tb_serial_parity_frame_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       odd_mode = 1'b0;
    logic       clear_cnt = 1'b0;

    logic       parity, in_frame, frame_done, parity_err;
    logic [7:0] err_count;
    logic       parity2, in_frame2, frame_done2, parity_err2;
    logic [1:0] err_count2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    serial_parity_frame_checker #(.FRAME_LEN(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .odd_mode(odd_mode), .clear_cnt(clear_cnt),
        .parity(parity), .in_frame(in_frame), .frame_done(frame_done),
        .parity_err(parity_err), .err_count(err_count)
    );

    serial_parity_frame_checker #(.FRAME_LEN(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .odd_mode(odd_mode), .clear_cnt(clear_cnt),
        .parity(parity2), .in_frame(in_frame2), .frame_done(frame_done2),
        .parity_err(parity_err2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change on the falling edge, outputs sampled 1 after the rising edge.
    task automatic step(input logic v, input logic b);
        @(negedge clock);
        in_valid = v;
        in_bit   = b;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic exp_err, input logic clr);
        logic run;
        run = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, d[i]);
            run = run ^ d[i];
            chk("data_parity", parity, run);
            chk("data_in_frame", in_frame, 1);
            chk("data_no_done", frame_done, 0);
        end
        clear_cnt = clr;
        step(1'b1, p);
        clear_cnt = 1'b0;
        chk("frame_done", frame_done, 1);
        chk("parity_err", parity_err, exp_err);
        chk("parity_cleared", parity, 0);
        chk("in_frame_cleared", in_frame, 0);
    endtask

    logic [1:0] sat_exp [5];
    logic [3:0] gap_bits;
    logic [3:0] gap_par;

    initial begin
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        gap_bits = 4'b1100;
        gap_par  = 4'b1000;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_parity", parity, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", parity_err, 0);
        chk("rst_count", err_count, 0);

        // Even parity, data 1,0,1,1 then parity bit 1
        step(1'b1, 1'b1); chk("t1_p0", parity, 1); chk("t1_frame", in_frame, 1);
        step(1'b1, 1'b0); chk("t1_p1", parity, 1);
        step(1'b1, 1'b1); chk("t1_p2", parity, 0);
        step(1'b1, 1'b1); chk("t1_p3", parity, 1);
        step(1'b1, 1'b1);
        chk("t1_done", frame_done, 1);
        chk("t1_err", parity_err, 0);
        chk("t1_parity_zero", parity, 0);
        chk("t1_count", err_count, 0);
        step(1'b0, 1'b0);
        chk("t1_done_pulse", frame_done, 0);

        // Odd parity: good frame, then bad frame
        odd_mode = 1'b1;
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
        chk("t2_count0", err_count, 0);
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        chk("t2_count1", err_count, 1);
        step(1'b0, 1'b0);
        chk("t2_err_pulse", parity_err, 0);
        chk("t2_done_pulse", frame_done, 0);
        odd_mode = 1'b0;

        // in_valid gaps of three cycles between bits
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, gap_bits[i]);
            chk("t3_parity", parity, gap_par[i]);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b1);
                chk("t3_gap_parity", parity, gap_par[i]);
                chk("t3_gap_frame", in_frame, 1);
                chk("t3_gap_done", frame_done, 0);
                chk("t3_gap_err", parity_err, 0);
            end
        end
        step(1'b1, 1'b0);
        chk("t3_done", frame_done, 1);
        chk("t3_err", parity_err, 0);
        chk("t3_count", err_count, 1);
        step(1'b0, 1'b0);
        chk("t3_done_pulse", frame_done, 0);

        // Saturation with CNT_W=2, five erroneous frames back to back
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        chk("t4_rst_count2", err_count2, 0);
        for (int f = 0; f < 5; f++) begin
            send_frame(4'b1000, 1'b0, 1'b1, 1'b0);
            chk("t4_done2", frame_done2, 1);
            chk("t4_err2", parity_err2, 1);
            chk("t4_count2", err_count2, sat_exp[f]);
            chk("t4_count8", err_count, f + 1);
        end

        // Reset after two data bits of a frame
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t5_pre_parity", parity, 0);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        chk("t5_rst_parity", parity, 0);
        chk("t5_rst_frame", in_frame, 0);
        chk("t5_rst_done", frame_done, 0);
        chk("t5_rst_count", err_count, 0);
        send_frame(4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_done_pulse", frame_done, 0);

        // clear_cnt coinciding with an error, then clear alone
        send_frame(4'b1000, 1'b0, 1'b1, 1'b0);
        send_frame(4'b1000, 1'b0, 1'b1, 1'b0);
        chk("t6_count2", err_count, 2);
        send_frame(4'b1000, 1'b0, 1'b1, 1'b1);
        chk("t6_clear_with_err", err_count, 1);
        clear_cnt = 1'b1;
        step(1'b0, 1'b0);
        clear_cnt = 1'b0;
        chk("t6_clear_alone", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_parity_frame_checker.md
Name: serial_parity_frame_checker

Overview:
Parametrised successor to the single-bit serial parity detector Moore machine. Accepts a qualified serial bit stream organised as frames of FRAME_LEN data bits, each followed by one parity bit. Tracks running parity as a Moore output and checks each received parity bit against a selectable even/odd rule. Reports per-frame completion and error pulses and keeps a saturating error counter. Sits behind a serial receiver front end and ahead of link-status logic.

Parameters:
FRAME_LEN, 8, number of data bits per frame before the parity bit (legal range >= 1)
CNT_W, 8, width of the saturating error counter (legal range >= 1)

Ports:
clock  input  1  single system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  qualifies in; a bit is accepted only on a posedge where in_valid=1
in  input  1  serial data/parity bit
odd_mode  input  1  0 = even parity (total ones incl. parity bit even), 1 = odd parity
clear_cnt  input  1  synchronous clear of err_count
parity  output  1  XOR of data bits accepted so far in the current frame (Moore, registered)
in_frame  output  1  1 while at least one data bit of the current frame has been accepted, or while in PARITY
frame_done  output  1  one-cycle pulse, cycle after a parity bit is accepted
parity_err  output  1  one-cycle pulse with frame_done when the parity bit mismatched
err_count  output  CNT_W  count of parity errors, saturating at all-ones

Behaviour:
- One clock domain (clock); reset is synchronous and active-high. All outputs are registered.
- Reset values: state=DATA, bit counter=0, parity=0, in_frame=0, frame_done=0, parity_err=0, err_count=0.
- Bit counter width is max(1, clog2(FRAME_LEN)). It counts accepted data bits from 0 to FRAME_LEN-1.
- State DATA, in_valid=1:
  - parity <= parity ^ in; in_frame <= 1.
  - If counter==FRAME_LEN-1, go to PARITY and set counter <= 0; otherwise counter++.
- State PARITY, in_valid=1: the bit is the parity bit.
  - Expected bit = parity ^ odd_mode, with odd_mode sampled in this same cycle.
  - Next cycle: frame_done=1; parity_err = (in != expected).
  - parity <= 0, in_frame <= 0, state <= DATA.
  - If FRAME_LEN=1, parity/in_frame behave identically; only one data bit precedes the parity bit.
- in_valid=0 in any state: state, counter, parity and in_frame hold. frame_done and parity_err are 0.
- frame_done and parity_err are never high for more than one cycle. A new frame's first data bit may be accepted in the cycle frame_done is high (back-to-back frames, no idle required).
- err_count:
  - Increments by 1 in the cycle parity_err is asserted.
  - Holds at 2^CNT_W-1 once saturated; never wraps.
- clear_cnt=1: err_count <= 0. If an error is registered in the same cycle, err_count <= 1, so the error is not lost.
- reset mid-frame: the partial frame is discarded and no frame_done/parity_err is produced for it. The next accepted bit is data bit 0. err_count returns to 0.
- parity in PARITY state equals the full data parity of the frame. It is visible for the whole wait for the parity bit.

Test Plan:
- FRAME_LEN=4, odd_mode=0, valid bits 1,0,1,1 then parity bit 1 -> parity output 1,1,0,1 after each data bit; frame_done=1, parity_err=0 one cycle after the parity bit; parity returns to 0; err_count=0.
- Same data with odd_mode=1: parity bit 0 -> no error. Repeat with parity bit 1 -> parity_err=1 with frame_done, err_count=1.
- in_valid gaps: data 1,1,0,0 with in_valid low for 3 cycles between each bit, then parity bit 0 (even) -> state/parity hold during gaps; single frame_done, no error, no spurious pulses.
- CNT_W=2: five consecutive erroneous frames sent back to back with no idle -> err_count 1,2,3,3,3; five frame_done pulses.
- reset asserted after 2 data bits of a frame, then 5 valid bits 0,0,0,1 + parity 1 (even) -> no pulse for the aborted frame; one frame_done, parity_err=0.
- clear_cnt asserted in the cycle an error registers with err_count=2 -> err_count=1. clear_cnt alone -> err_count=0.
